// File: rtl/scratch_stack_ram.sv
// scratch_stack_ram: scratch RAM with a descending hardware stack, sticky error flags
// and a post-reset clear sequencer.
module scratch_stack_ram #(
    parameter int DATA_WIDTH     = 10,
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  SCR_WE,
    input  logic [ADDR_WIDTH-1:0] SCR_ADDR,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic                  SP_LD,
    input  logic [ADDR_WIDTH-1:0] SP_DATA,
    input  logic                  ERR_CLR,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic [ADDR_WIDTH-1:0] SP_OUT,
    output logic                  BUSY,
    output logic                  STK_EMPTY,
    output logic                  STK_FULL,
    output logic                  OVF,
    output logic                  UNF,
    output logic                  ILL
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sp_q, sp_d, clr_q, clr_d, wa;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d, we;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= CLEAR_ON_RESET != 0 ? INIT : READY;
            sp_q    <= '0;
            cnt_q   <= '0;
            clr_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ill_q   <= ill_d;
        end
    end

    // Writes are blocked while reset is held so the clear always restarts cleanly.
    always_ff @(posedge CLK) begin
        if (we && !RST) mem[wa] <= wd;
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        ill_d   = ill_q;
        we      = 1'b0;
        wa      = SCR_ADDR;
        wd      = DATA_IN;
        if (state_q == INIT) begin
            we    = 1'b1;
            wa    = clr_q;
            wd    = '0;
            clr_d = clr_q + 1'b1;
            if (clr_q == LAST) state_d = READY;
        end else begin
            // Clear first so a same-cycle error set below wins.
            if (ERR_CLR) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                ill_d = 1'b0;
            end
            if (SP_LD) begin
                sp_d  = SP_DATA;
                cnt_d = '0;
            end else if (PUSH && POP) begin
                ill_d = 1'b1;
            end else if (PUSH) begin
                we    = 1'b1;
                wa    = sp_q - 1'b1;
                sp_d  = sp_q - 1'b1;
                ovf_d = (cnt_q == FULL) ? 1'b1 : ovf_d;
                cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
            end else if (POP) begin
                sp_d  = sp_q + 1'b1;
                unf_d = (cnt_q == '0) ? 1'b1 : unf_d;
                cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            end else if (SCR_WE) begin
                we = 1'b1;
            end
        end
    end

    assign DATA_OUT  = (state_q == INIT) ? '0 : mem[POP ? sp_q : SCR_ADDR];
    assign SP_OUT    = sp_q;
    assign BUSY      = state_q == INIT;
    assign STK_EMPTY = cnt_q == '0;
    assign STK_FULL  = cnt_q == FULL;
    assign OVF       = ovf_q;
    assign UNF       = unf_q;
    assign ILL       = ill_q;
endmodule

// File: tb/tb_scratch_stack_ram.sv
// tb_scratch_stack_ram: directed plan plus random traffic checked against an array/integer stack model.
module tb_scratch_stack_ram;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [9:0] DATA_IN = '0;
    logic       SCR_WE = 1'b0;
    logic [7:0] SCR_ADDR = '0;
    logic       PUSH = 1'b0;
    logic       POP = 1'b0;
    logic       SP_LD = 1'b0;
    logic [7:0] SP_DATA = '0;
    logic       ERR_CLR = 1'b0;
    logic [9:0] DATA_OUT;
    logic [7:0] SP_OUT;
    logic       BUSY, STK_EMPTY, STK_FULL, OVF, UNF, ILL;

    scratch_stack_ram dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .SCR_WE(SCR_WE), .SCR_ADDR(SCR_ADDR),
        .PUSH(PUSH), .POP(POP), .SP_LD(SP_LD), .SP_DATA(SP_DATA), .ERR_CLR(ERR_CLR),
        .DATA_OUT(DATA_OUT), .SP_OUT(SP_OUT), .BUSY(BUSY), .STK_EMPTY(STK_EMPTY),
        .STK_FULL(STK_FULL), .OVF(OVF), .UNF(UNF), .ILL(ILL)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    logic [9:0] mem_m [256];
    int sp_m, cnt_m, busy_m;
    bit ovf_m, unf_m, ill_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs();
        chk("sp", SP_OUT, sp_m);
        chk("busy", BUSY, busy_m > 0);
        chk("empty", STK_EMPTY, cnt_m == 0);
        chk("full", STK_FULL, cnt_m == 256);
        chk("ovf", OVF, ovf_m);
        chk("unf", UNF, unf_m);
        chk("ill", ILL, ill_m);
    endtask

    // One clock: drive, check the combinational read, clock, advance model, check state.
    task automatic cyc(input logic [9:0] d, input logic we, input logic [7:0] a, input logic pu,
                       input logic po, input logic ld, input logic [7:0] sd, input logic ec);
        DATA_IN = d; SCR_WE = we; SCR_ADDR = a; PUSH = pu; POP = po;
        SP_LD = ld; SP_DATA = sd; ERR_CLR = ec;
        #1;
        chk("dout", DATA_OUT, busy_m > 0 ? 10'd0 : mem_m[po ? sp_m : int'(a)]);
        @(posedge CLK);
        if (busy_m > 0) begin
            mem_m[256 - busy_m] = '0;
            busy_m--;
        end else begin
            if (ec) begin ovf_m = 0; unf_m = 0; ill_m = 0; end
            if (ld) begin
                sp_m = sd; cnt_m = 0;
            end else if (pu && po) begin
                ill_m = 1;
            end else if (pu) begin
                sp_m = (sp_m + 255) % 256;
                mem_m[sp_m] = d;
                if (cnt_m == 256) ovf_m = 1; else cnt_m++;
            end else if (po) begin
                sp_m = (sp_m + 1) % 256;
                if (cnt_m == 0) unf_m = 1; else cnt_m--;
            end else if (we) begin
                mem_m[a] = d;
            end
        end
        #1;
        check_regs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 0, '0, 0, 0, 0, '0, 0);
    endtask

    task automatic rst_pulse();
        RST = 1'b1;
        DATA_IN = '0; SCR_WE = 0; PUSH = 0; POP = 0; SP_LD = 0; ERR_CLR = 0;
        sp_m = 0; cnt_m = 0; ovf_m = 0; unf_m = 0; ill_m = 0; busy_m = 256;
        #2;
        check_regs();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        @(posedge CLK);
        #1;
        rst_pulse();
        idle(100);
        rst_pulse();
        idle(256);
        chk("busy_end", BUSY, 0);
        for (int i = 0; i < 256; i++) cyc('0, 0, 8'(i), 0, 0, 0, '0, 0);

        cyc(10'h2A5, 1, 8'h10, 0, 0, 0, '0, 0);
        cyc('0, 0, 8'h10, 0, 0, 0, '0, 0);
        chk("dir_sp", SP_OUT, 8'h00);

        for (int i = 1; i <= 3; i++) cyc(10'(i), 0, '0, 1, 0, 0, '0, 0);
        chk("push3_sp", SP_OUT, 8'hFD);
        for (int i = 0; i < 3; i++) cyc('0, 0, '0, 0, 1, 0, '0, 0);
        chk("pop3_sp", SP_OUT, 8'h00);
        chk("pop3_empty", STK_EMPTY, 1);

        cyc('0, 0, '0, 0, 1, 0, '0, 0);
        chk("unf_set", UNF, 1);
        cyc('0, 0, '0, 0, 0, 0, '0, 1);
        chk("unf_clr", UNF, 0);
        cyc('0, 0, '0, 0, 1, 0, '0, 1);
        chk("unf_setwins", UNF, 1);

        cyc('0, 0, '0, 0, 0, 1, 8'h80, 1);
        for (int i = 0; i < 256; i++) cyc(10'($urandom), 0, '0, 1, 0, 0, '0, 0);
        chk("full_256", STK_FULL, 1);
        chk("no_ovf", OVF, 0);
        cyc(10'h3C3, 0, '0, 1, 0, 0, '0, 0);
        chk("ovf_sp", SP_OUT, 8'h7F);
        chk("ovf_set", OVF, 1);
        cyc('0, 0, 8'h7F, 0, 0, 0, '0, 0);

        cyc(10'h155, 1, 8'h7F, 1, 1, 0, '0, 0);
        chk("ill_set", ILL, 1);
        cyc('0, 0, 8'h7F, 0, 0, 0, '0, 0);
        cyc(10'h0AA, 0, '0, 1, 0, 1, 8'h40, 1);
        chk("ld_sp", SP_OUT, 8'h40);
        chk("ld_empty", STK_EMPTY, 1);
        cyc('0, 0, 8'h3F, 0, 0, 0, '0, 0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cyc(10'($urandom), r >= 60, 8'($urandom), (r < 35) || (r >= 96),
                (r >= 30 && r < 58) || (r >= 96), $urandom_range(0, 40) == 0, 8'($urandom),
                $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
